// File: rtl/arm_pkg.sv
// Shared definitions for the ARM rotated-immediate encoder: FSM states, field
// widths and a 32-bit rotate-left helper usable from RTL and testbench.
package arm_pkg;

    localparam int IMM8_W = 8;
    localparam int ROT_W  = 4;
    localparam int SHOP_W = 12;

    typedef enum logic [1:0] {
        ENC_IDLE   = 2'd0,
        ENC_SEARCH = 2'd1,
        ENC_RESULT = 2'd2
    } enc_state_e;

    function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amount);
        logic [63:0] dbl_s;
        dbl_s = {value, value} << amount;
        return dbl_s[63:32];
    endfunction

endpackage

// File: rtl/arm_imm_encoder_if.sv
// Request/response bundle of the immediate encoder: constant in, shift_operand out.
interface arm_imm_encoder_if;
    import arm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_value;
    logic              out_valid;
    logic              out_ready;
    logic              out_encodable;
    logic              out_invert;
    logic [SHOP_W-1:0] out_shift_operand;

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_encodable, out_invert, out_shift_operand
    );

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_encodable, out_invert, out_shift_operand
    );

endinterface

// File: rtl/imm_rot_checker.sv
// Tests one rotation: does ROL(work, 2*rot) fit in the low byte?
module imm_rot_checker
    import arm_pkg::*;
(
    input  logic [31:0]       work,
    input  logic [ROT_W-1:0]  rot,
    output logic              hit,
    output logic [IMM8_W-1:0] imm8
);

    logic [31:0] cand_s;

    // Undo the decoder's ROR; a valid encoding leaves only imm8 populated.
    always_comb begin
        cand_s = rol32(work, {rot, 1'b0});
        hit    = (cand_s[31:IMM8_W] == 24'd0);
        imm8   = cand_s[IMM8_W-1:0];
    end

endmodule

// File: rtl/arm_imm_encoder.sv
// Iterative ARM operand-2 immediate encoder: one rotation per cycle, direct
// pass first and, when TRY_INVERT is set, a second pass over ~value (MVN form).
module arm_imm_encoder
    import arm_pkg::*;
#(
    parameter bit TRY_INVERT = 1'b1
)
(
    input  logic             clk,
    input  logic             rst,
    arm_imm_encoder_if.slave bus,
    output logic             busy
);

    enc_state_e        state_r, state_next_s;
    logic [ROT_W-1:0]  rot_r, rot_next_s;
    logic              pass_r, pass_next_s;
    logic [31:0]       value_r, value_next_s;
    logic              enc_r, enc_next_s;
    logic              inv_r, inv_next_s;
    logic [SHOP_W-1:0] shop_r, shop_next_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    logic [31:0]       work_s;
    logic              hit_s;
    logic [IMM8_W-1:0] imm8_s;

    // Select the operand under test for the current pass.
    always_comb begin
        if (pass_r) begin
            work_s = ~value_r;
        end else begin
            work_s = value_r;
        end
    end

    imm_rot_checker u_checker (
        .work (work_s),
        .rot  (rot_r),
        .hit  (hit_s),
        .imm8 (imm8_s)
    );

    // Next-state and result computation; search order gives the canonical encoding.
    always_comb begin
        state_next_s = state_r;
        rot_next_s   = rot_r;
        pass_next_s  = pass_r;
        value_next_s = value_r;
        enc_next_s   = enc_r;
        inv_next_s   = inv_r;
        shop_next_s  = shop_r;
        case (state_r)
            ENC_IDLE: begin
                if (bus.in_valid) begin
                    value_next_s = bus.in_value;
                    rot_next_s   = 4'd0;
                    pass_next_s  = 1'b0;
                    state_next_s = ENC_SEARCH;
                end else begin
                    state_next_s = ENC_IDLE;
                end
            end
            ENC_SEARCH: begin
                if (hit_s) begin
                    shop_next_s  = {rot_r, imm8_s};
                    inv_next_s   = pass_r;
                    enc_next_s   = 1'b1;
                    state_next_s = ENC_RESULT;
                end else if (rot_r != 4'd15) begin
                    rot_next_s   = rot_r + 4'd1;
                end else if (TRY_INVERT && !pass_r) begin
                    pass_next_s  = 1'b1;
                    rot_next_s   = 4'd0;
                end else begin
                    enc_next_s   = 1'b0;
                    inv_next_s   = 1'b0;
                    shop_next_s  = 12'd0;
                    state_next_s = ENC_RESULT;
                end
            end
            ENC_RESULT: begin
                if (bus.out_ready) begin
                    state_next_s = ENC_IDLE;
                end else begin
                    state_next_s = ENC_RESULT;
                end
            end
            default: begin
                state_next_s = ENC_IDLE;
            end
        endcase
    end

    // State, search registers and registered outputs (flags decoded from next state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ENC_IDLE;
            rot_r       <= 4'd0;
            pass_r      <= 1'b0;
            value_r     <= 32'd0;
            enc_r       <= 1'b0;
            inv_r       <= 1'b0;
            shop_r      <= 12'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rot_r       <= rot_next_s;
            pass_r      <= pass_next_s;
            value_r     <= value_next_s;
            enc_r       <= enc_next_s;
            inv_r       <= inv_next_s;
            shop_r      <= shop_next_s;
            in_ready_r  <= (state_next_s == ENC_IDLE);
            out_valid_r <= (state_next_s == ENC_RESULT);
            busy_r      <= (state_next_s == ENC_SEARCH);
        end
    end

    assign bus.in_ready          = in_ready_r;
    assign bus.out_valid         = out_valid_r;
    assign bus.out_encodable     = enc_r;
    assign bus.out_invert        = inv_r;
    assign bus.out_shift_operand = shop_r;
    assign busy                  = busy_r;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Directed bench for arm_imm_encoder: one instance with TRY_INVERT=1, one with 0,
// results checked against hand-computed vectors and an operand-2 ROR decoder.
module tb_arm_imm_encoder;
    import arm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy_i, busy_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    arm_imm_encoder_if bus_i ();
    arm_imm_encoder_if bus_n ();

    arm_imm_encoder #(.TRY_INVERT(1'b1)) dut_i (.clk(clk), .rst(rst), .bus(bus_i.slave), .busy(busy_i));
    arm_imm_encoder #(.TRY_INVERT(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n.slave), .busy(busy_n));

    typedef struct packed {
        logic        ir;
        logic        ov;
        logic        enc;
        logic        inv;
        logic        busy;
        logic [11:0] shop;
    } obs_t;

    typedef struct {
        bit          sel;
        logic [31:0] value;
        logic        enc;
        logic        inv;
        logic [11:0] shop;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic obs_t observe(input bit sel);
        obs_t o;
        if (sel) o = '{bus_i.in_ready, bus_i.out_valid, bus_i.out_encodable, bus_i.out_invert, busy_i, bus_i.out_shift_operand};
        else     o = '{bus_n.in_ready, bus_n.out_valid, bus_n.out_encodable, bus_n.out_invert, busy_n, bus_n.out_shift_operand};
        return o;
    endfunction

    task automatic drive_in(input bit sel, input logic v, input logic [31:0] val);
        if (sel) begin bus_i.in_valid = v; bus_i.in_value = val; end
        else     begin bus_n.in_valid = v; bus_n.in_value = val; end
    endtask

    task automatic drive_ready(input bit sel, input logic v);
        if (sel) bus_i.out_ready = v;
        else     bus_n.out_ready = v;
    endtask

    // Reference operand-2 decode: ROR(zext(imm8), 2*rot).
    function automatic logic [31:0] op2_decode(input logic [11:0] sh);
        logic [31:0] imm;
        int          amt;
        imm = {24'd0, sh[7:0]};
        amt = 2 * int'(sh[11:8]);
        if (amt == 0) return imm;
        return (imm >> amt) | (imm << (32 - amt));
    endfunction

    // Issue one request; lat counts edges from accept to out_valid (bounded).
    task automatic run_req(input bit sel, input logic [31:0] val, output int lat, output obs_t o);
        @(negedge clk);
        check("idle_in_ready", 32'(observe(sel).ir), 32'd1);
        drive_ready(sel, 1'b0);
        drive_in(sel, 1'b1, val);
        @(posedge clk);
        #1;
        drive_in(sel, 1'b0, 32'd0);
        o = observe(sel);
        check("accept_busy", 32'(o.busy), 32'd1);
        check("accept_in_ready", 32'(o.ir), 32'd0);
        lat = 0;
        o.ov = 1'b0;
        while (!o.ov && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            o = observe(sel);
        end
    endtask

    task automatic handshake(input bit sel);
        obs_t o;
        @(negedge clk);
        drive_ready(sel, 1'b1);
        @(posedge clk);
        #1;
        drive_ready(sel, 1'b0);
        o = observe(sel);
        check("post_hs_out_valid", 32'(o.ov), 32'd0);
        check("post_hs_in_ready", 32'(o.ir), 32'd1);
    endtask

    initial begin
        obs_t o;
        int   lat;
        bit   seen;

        vecs[0] = '{1'b1, 32'h000000FF, 1'b1, 1'b0, 12'h0FF, 1};
        vecs[1] = '{1'b1, 32'hFF000000, 1'b1, 1'b0, 12'h4FF, 5};
        vecs[2] = '{1'b1, 32'hF000000F, 1'b1, 1'b0, 12'h2FF, 3};
        vecs[3] = '{1'b1, 32'hFFFFFF00, 1'b1, 1'b1, 12'h0FF, 17};
        vecs[4] = '{1'b0, 32'hFFFFFF00, 1'b0, 1'b0, 12'h000, 16};
        vecs[5] = '{1'b1, 32'h00000000, 1'b1, 1'b0, 12'h000, 1};
        vecs[6] = '{1'b1, 32'hC000003F, 1'b1, 1'b0, 12'h1FF, 2};
        vecs[7] = '{1'b1, 32'h00FFFFFF, 1'b1, 1'b1, 12'h4FF, 21};
        vecs[8] = '{1'b0, 32'h000003FC, 1'b1, 1'b0, 12'hFFF, 16};
        vecs[9] = '{1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 12'h000, 17};

        rst = 1'b1;
        drive_in(1'b1, 1'b0, 32'd0);
        drive_in(1'b0, 1'b0, 32'd0);
        drive_ready(1'b1, 1'b0);
        drive_ready(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        o = observe(1'b1);
        check("rst_in_ready", 32'(o.ir), 32'd1);
        check("rst_out_valid", 32'(o.ov), 32'd0);
        check("rst_busy", 32'(o.busy), 32'd0);
        check("rst_encodable", 32'(o.enc), 32'd0);
        check("rst_invert", 32'(o.inv), 32'd0);
        check("rst_shop", 32'(o.shop), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].sel, vecs[i].value, lat, o);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_encodable", i), 32'(o.enc), 32'(vecs[i].enc));
            check($sformatf("v%0d_invert", i), 32'(o.inv), 32'(vecs[i].inv));
            check($sformatf("v%0d_shop", i), 32'(o.shop), 32'(vecs[i].shop));
            if (vecs[i].enc)
                check($sformatf("v%0d_decode", i),
                      op2_decode(o.shop) ^ (o.inv ? 32'hFFFFFFFF : 32'h0), vecs[i].value);
            handshake(vecs[i].sel);
        end

        // Unencodable odd-aligned span, result held under back-pressure.
        run_req(1'b1, 32'h00000102, lat, o);
        check("odd_latency", 32'(lat), 32'd32);
        check("odd_encodable", 32'(o.enc), 32'd0);
        check("odd_invert", 32'(o.inv), 32'd0);
        check("odd_shop", 32'(o.shop), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) drive_in(1'b1, 1'b1, 32'h00000001);
            if (k == 2) drive_in(1'b1, 1'b0, 32'd0);
            @(posedge clk);
            #1;
            o = observe(1'b1);
            check("hold_out_valid", 32'(o.ov), 32'd1);
            check("hold_in_ready", 32'(o.ir), 32'd0);
            check("hold_busy", 32'(o.busy), 32'd0);
            check("hold_shop", 32'(o.shop), 32'd0);
        end
        @(negedge clk);
        drive_in(1'b1, 1'b1, 32'h00000001);
        drive_ready(1'b1, 1'b1);
        @(posedge clk);
        #1;
        drive_in(1'b1, 1'b0, 32'd0);
        drive_ready(1'b1, 1'b0);
        o = observe(1'b1);
        check("hs_idle_in_ready", 32'(o.ir), 32'd1);
        check("hs_idle_out_valid", 32'(o.ov), 32'd0);
        @(posedge clk);
        #1;
        check("hs_no_accept_busy", 32'(observe(1'b1).busy), 32'd0);

        // Reset during the third search cycle discards the request.
        @(negedge clk);
        drive_in(1'b1, 1'b1, 32'hFF000000);
        @(posedge clk);
        #1;
        drive_in(1'b1, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        o = observe(1'b1);
        check("midrst_in_ready", 32'(o.ir), 32'd1);
        check("midrst_out_valid", 32'(o.ov), 32'd0);
        check("midrst_busy", 32'(o.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (observe(1'b1).ov) seen = 1'b1;
        end
        check("midrst_discarded", 32'(seen), 32'd0);
        run_req(1'b1, 32'h000003FC, lat, o);
        check("after_rst_latency", 32'(lat), 32'd16);
        check("after_rst_encodable", 32'(o.enc), 32'd1);
        check("after_rst_shop", 32'(o.shop), 32'hFFF);
        handshake(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
